// File: rtl/chu_msg_sched.sv
// chu_msg_sched: message-schedule stage of the hash core.
// Captures one padded 512-bit block and streams the per-round schedule word
// W_t (SHA-1, SHA-256 or MD5) to the compression round, one word per beat.
module chu_msg_sched (
    input  logic         sys_clk,
    input  logic         sys_rst,
    input  logic [511:0] in_w,
    input  logic [15:0]  in_w_val,
    input  logic [7:0]   in_mes_cnt,
    input  logic [2:0]   in_alg,
    output logic         in_rdy,
    output logic         out_val,
    input  logic         out_rdy,
    output logic [31:0]  out_w,
    output logic [6:0]   out_t,
    output logic         out_last,
    output logic [2:0]   out_alg,
    output logic [7:0]   out_mes_cnt,
    output logic         drop
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [2:0] ALG_SHA1   = 3'd0;
    localparam logic [2:0] ALG_SHA256 = 3'd1;

    state_t      state;
    state_t      state_nxt;

    // SHA sliding window: window[0] is the current W_t.
    logic [31:0] window  [16];
    // Unshifted copy of the captured block, indexed by MD5.
    logic [31:0] blk_buf [16];

    logic [6:0]  t;
    logic [2:0]  alg;
    logic [7:0]  mes_cnt;

    logic        capture;
    logic        beat;
    logic        last_t;
    logic        is_sha;
    logic [3:0]  t4;
    logic [3:0]  g;
    logic [31:0] sha1_new;
    logic [31:0] sha256_new;
    logic [31:0] new_w;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

    // State register; reset abandons any block in flight.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode: capture only full blocks, flag partial ones.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        beat      = 1'b0;
        in_rdy    = 1'b0;
        out_val   = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                in_rdy = 1'b1;
                if (in_w_val == 16'hFFFF) begin
                    capture   = 1'b1;
                    state_nxt = RUN;
                end else if (in_w_val != 16'h0000) begin
                    drop = 1'b1;
                end
            end
            RUN: begin
                out_val = 1'b1;
                beat    = out_rdy;
                if (out_rdy && last_t) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Final round index depends on the algorithm (80 rounds for SHA-1, else 64).
    always_comb begin
        last_t = 1'b0;
        if (alg == ALG_SHA1) begin
            last_t = (t == 7'd79);
        end else begin
            last_t = (t == 7'd63);
        end
    end

    // MD5 message-word index g for the four 16-round groups.
    always_comb begin
        t4 = t[3:0];
        g  = t4;
        case (t[5:4])
            2'd0:    g = t4;
            2'd1:    g = t4 * 4'd5 + 4'd1;
            2'd2:    g = t4 * 4'd3 + 4'd5;
            2'd3:    g = t4 * 4'd7;
            default: g = t4;
        endcase
    end

    // Next schedule word entering the top of the SHA window.
    always_comb begin
        sha1_new   = window[13] ^ window[8] ^ window[2] ^ window[0];
        sha1_new   = {sha1_new[30:0], sha1_new[31]};
        sha256_new = sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0];
        new_w      = (alg == ALG_SHA1) ? sha1_new : sha256_new;
    end

    // Output word selection: window head for SHA, permuted buffer word for MD5.
    always_comb begin
        is_sha = (alg == ALG_SHA1) || (alg == ALG_SHA256);
        out_w  = is_sha ? window[0] : blk_buf[g];
    end

    assign out_t       = t;
    assign out_last    = (state == RUN) && last_t;
    assign out_alg     = alg;
    assign out_mes_cnt = mes_cnt;

    // Block capture, round counter and window shift on each accepted beat.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int i = 0; i < 16; i++) begin
                window[i]  <= 32'd0;
                blk_buf[i] <= 32'd0;
            end
            t       <= 7'd0;
            alg     <= 3'd0;
            mes_cnt <= 8'd0;
        end else if (capture) begin
            for (int i = 0; i < 16; i++) begin
                window[i]  <= in_w[32*i +: 32];
                blk_buf[i] <= in_w[32*i +: 32];
            end
            t       <= 7'd0;
            alg     <= in_alg;
            mes_cnt <= in_mes_cnt;
        end else if (beat) begin
            t <= t + 7'd1;
            if (is_sha) begin
                for (int i = 0; i < 15; i++) begin
                    window[i] <= window[i+1];
                end
                window[15] <= new_w;
            end
        end
    end

endmodule

// File: tb/tb_chu_msg_sched.sv
// tb_chu_msg_sched: directed bench for the message-schedule stage with a
// reference schedule model feeding an expected-word scoreboard.
module tb_chu_msg_sched;

    logic         sys_clk = 1'b0;
    logic         sys_rst;
    logic [511:0] in_w;
    logic [15:0]  in_w_val;
    logic [7:0]   in_mes_cnt;
    logic [2:0]   in_alg;
    logic         in_rdy;
    logic         out_val;
    logic         out_rdy;
    logic [31:0]  out_w;
    logic [6:0]   out_t;
    logic         out_last;
    logic [2:0]   out_alg;
    logic [7:0]   out_mes_cnt;
    logic         drop;

    typedef struct {
        logic [31:0] w;
        logic [6:0]  t;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] blk [16];
    int          pass_cnt  = 0;
    int          total_cnt = 0;

    // Free-running clock.
    always #5 sys_clk = ~sys_clk;

    chu_msg_sched dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .in_w        (in_w),
        .in_w_val    (in_w_val),
        .in_mes_cnt  (in_mes_cnt),
        .in_alg      (in_alg),
        .in_rdy      (in_rdy),
        .out_val     (out_val),
        .out_rdy     (out_rdy),
        .out_w       (out_w),
        .out_t       (out_t),
        .out_last    (out_last),
        .out_alg     (out_alg),
        .out_mes_cnt (out_mes_cnt),
        .drop        (drop)
    );

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference schedule from the textbook recurrences, pushed to the scoreboard.
    task automatic push_expected(input logic [2:0] alg);
        logic [31:0] wv [80];
        logic [31:0] x;
        int          n;
        int          g;
        exp_t        e;
        n = (alg == 3'd0) ? 80 : 64;
        for (int i = 0; i < 16; i++) wv[i] = blk[i];
        for (int i = 16; i < 80; i++) begin
            if (alg == 3'd0) begin
                x = wv[i-3] ^ wv[i-8] ^ wv[i-14] ^ wv[i-16];
                wv[i] = rotr32(x, 31);
            end else if (alg == 3'd1) begin
                wv[i] = (rotr32(wv[i-2], 17) ^ rotr32(wv[i-2], 19) ^ (wv[i-2] >> 10))
                      + wv[i-7]
                      + (rotr32(wv[i-15], 7) ^ rotr32(wv[i-15], 18) ^ (wv[i-15] >> 3))
                      + wv[i-16];
            end else begin
                wv[i] = 32'd0;
            end
        end
        for (int i = 0; i < n; i++) begin
            if (alg == 3'd0 || alg == 3'd1) begin
                e.w = wv[i];
            end else begin
                case (i / 16)
                    0:       g = i;
                    1:       g = (5 * i + 1) % 16;
                    2:       g = (3 * i + 5) % 16;
                    default: g = (7 * i) % 16;
                endcase
                e.w = blk[g];
            end
            e.t    = 7'(i);
            e.last = (i == n - 1);
            sb.push_back(e);
        end
    endtask

    // Present blk as a full block and confirm it was taken.
    task automatic apply_stimulus(input logic [2:0] alg, input logic [7:0] cnt);
        for (int i = 0; i < 16; i++) in_w[32*i +: 32] = blk[i];
        in_w_val   = 16'hFFFF;
        in_alg     = alg;
        in_mes_cnt = cnt;
        push_expected(alg);
        @(negedge sys_clk);
        in_w_val   = 16'h0000;
        check("capture_out_val", {31'd0, out_val}, 32'd1);
        check("capture_in_rdy", {31'd0, in_rdy}, 32'd0);
        check("out_alg", {29'd0, out_alg}, {29'd0, alg});
        check("out_mes_cnt", {24'd0, out_mes_cnt}, {24'd0, cnt});
    endtask

    // Drain the scoreboard against DUT beats; optionally stop at round abort_t.
    task automatic check_output(input bit random_rdy, input int abort_t);
        int cyc = 0;
        while (sb.size() > 0 && cyc < 2000) begin
            if (!out_val) begin
                check("out_val_in_run", {31'd0, out_val}, 32'd1);
                sb.delete();
                break;
            end
            if (abort_t >= 0 && int'(sb[0].t) == abort_t) begin
                out_rdy = 1'b0;
                check("abort_out_t", {25'd0, out_t}, {25'd0, sb[0].t});
                return;
            end
            check("out_w", out_w, sb[0].w);
            check("out_t", {25'd0, out_t}, {25'd0, sb[0].t});
            check("out_last", {31'd0, out_last}, {31'd0, sb[0].last});
            check("in_rdy_run", {31'd0, in_rdy}, 32'd0);
            out_rdy = random_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_rdy) void'(sb.pop_front());
            @(negedge sys_clk);
            cyc++;
        end
        if (sb.size() > 0) begin
            check("cycle_budget", 32'd0, 32'd1);
            sb.delete();
        end
        out_rdy = 1'b0;
        check("end_out_val", {31'd0, out_val}, 32'd0);
        check("end_in_rdy", {31'd0, in_rdy}, 32'd1);
    endtask

    task automatic check_reset_state();
        check("rst_in_rdy", {31'd0, in_rdy}, 32'd1);
        check("rst_out_val", {31'd0, out_val}, 32'd0);
        check("rst_out_w", out_w, 32'd0);
        check("rst_out_t", {25'd0, out_t}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_out_alg", {29'd0, out_alg}, 32'd0);
        check("rst_out_mes_cnt", {24'd0, out_mes_cnt}, 32'd0);
        check("rst_drop", {31'd0, drop}, 32'd0);
    endtask

    task automatic load_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'd0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
    endtask

    // Directed sequence of scenarios.
    initial begin
        sys_rst    = 1'b1;
        in_w       = '0;
        in_w_val   = 16'h0000;
        in_mes_cnt = 8'd0;
        in_alg     = 3'd0;
        out_rdy    = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        check_reset_state();

        $display("[TB] SHA-256 abc, no stall");
        load_abc();
        apply_stimulus(3'd1, 8'h11);
        check("sha256_w16_model", sb[16].w, 32'h61626380);
        check("sha256_w17_model", sb[17].w, 32'h000F0000);
        check_output(1'b0, -1);

        $display("[TB] SHA-1 abc, no stall");
        load_abc();
        apply_stimulus(3'd0, 8'h22);
        check("sha1_w16_model", sb[16].w, 32'hC2C4C700);
        check("sha1_len", sb.size(), 32'd80);
        check_output(1'b0, -1);

        $display("[TB] MD5 word permutation");
        for (int i = 0; i < 16; i++) blk[i] = 32'(i);
        apply_stimulus(3'd2, 8'h33);
        check("md5_t16_model", sb[16].w, 32'd1);
        check("md5_t48_model", sb[48].w, 32'd0);
        check_output(1'b0, -1);

        $display("[TB] SHA-256 abc, random backpressure");
        load_abc();
        apply_stimulus(3'd1, 8'h44);
        check_output(1'b1, -1);

        $display("[TB] partial block then full block");
        in_w_val = 16'h7FFF;
        #1;
        check("partial_drop", {31'd0, drop}, 32'd1);
        check("partial_in_rdy", {31'd0, in_rdy}, 32'd1);
        @(negedge sys_clk);
        check("partial_no_val", {31'd0, out_val}, 32'd0);
        in_w_val = 16'h0000;
        #1;
        check("idle_no_drop", {31'd0, drop}, 32'd0);
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        apply_stimulus(3'd1, 8'h55);
        check_output(1'b0, -1);

        $display("[TB] reset during SHA-1 at t=20");
        load_abc();
        apply_stimulus(3'd0, 8'h5A);
        check_output(1'b0, 20);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        sb.delete();
        check_reset_state();
        apply_stimulus(3'd0, 8'h66);
        check("restart_t0", {25'd0, out_t}, 32'd0);
        check_output(1'b0, -1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/chu_msg_sched.md
# chu_msg_sched

Message-schedule stage of the hash core. Sits directly downstream of the padding stage: it captures one complete padded 512-bit block (16 × 32-bit words plus per-word valid flags and message counter) and emits the per-round schedule word W_t, one per accepted beat, to the compression round. It supports SHA-1 (80 rounds), SHA-256 (64 rounds) and MD5 (64 rounds, word permutation).

## Interface
Parameters:
- none (block size fixed at 16 words, word width fixed at 32)

Ports:
- sys_clk  in  1  clock; all logic on posedge
- sys_rst  in  1  synchronous, active-high reset
- in_w  in  512  padded block; word i on bits [32*i+31:32*i]
- in_w_val  in  16  per-word valid; bit i qualifies word i
- in_mes_cnt  in  8  message counter from pad stage
- in_alg  in  3  algorithm: 3'd0 SHA-1, 3'd1 SHA-256, any other value MD5
- in_rdy  out  1  block can be captured (state IDLE)
- out_val  out  1  out_w is valid
- out_rdy  in  1  downstream accepts the current word
- out_w  out  32  schedule word W_t
- out_t  out  7  round index t
- out_last  out  1  high with the final word of the block (t = 79 or 63)
- out_alg  out  3  latched algorithm
- out_mes_cnt  out  8  latched message counter
- drop  out  1  one-cycle pulse: partial block presented and discarded

## Operation
- States: IDLE, RUN.
- IDLE: in_rdy=1. Capture when in_w_val == 16'hFFFF. On capture, latch the 16 words into window[0..15], latch in_alg and in_mes_cnt, set t=0, and go to RUN.
- IDLE with in_w_val nonzero but not all-ones: no capture, and drop=1 for that cycle. in_w_val == 0 is idle with no drop.
- RUN: in_rdy=0, out_val=1, out_t=t. Inputs are ignored.
- Output word:
  - SHA: out_w = window[0].
  - MD5: out_w = buf[g], with buf holding the unshifted captured block. g = t for t<16; (5t+1) mod 16 for 16–31; (3t+5) mod 16 for 32–47; 7t mod 16 for 48–63.
- Beat = out_val & out_rdy. On each beat:
  - t increments.
  - SHA: window shifts down one (window[i] ← window[i+1]) and window[15] ← new word.
  - New word for SHA-1: rotl1(window[13]^window[8]^window[2]^window[0]).
  - New word for SHA-256: σ1(window[14]) + window[9] + σ0(window[1]) + window[0], mod 2^32. σ0 = rotr7^rotr18^shr3; σ1 = rotr17^rotr19^shr10.
- out_last = 1 when t == 79 (SHA-1) or t == 63 (otherwise). A beat with out_last returns to IDLE.
- No beat: all state holds, and out_w/out_t remain stable.
- Byte order is not changed; the pad stage delivers words in algorithm order.

## Timing
- Reset values: state IDLE, in_rdy=1, out_val=0, out_w=0, out_t=0, out_last=0, out_alg=0, out_mes_cnt=0, drop=0, window/buf=0.
- Reset is honoured in any state. Reset mid-RUN abandons the block; the cycle after reset deasserts shows IDLE.
- Capture at edge k gives out_val=1 with W_0 from cycle k+1.
- Throughput with out_rdy held high: one word per cycle, so a block takes 80 or 64 cycles in RUN plus 1 IDLE cycle before the next capture. in_rdy is 0 for the whole RUN, including the last-beat cycle.
- in_rdy is combinational from state. The pad stage must hold the block until it sees in_rdy=1 with all valids.
- Window update and out_t increment happen at the same edge as the beat; there is no extra pipeline bubble.

## Test plan
- SHA-256 "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018, alg=1, out_rdy=1): W16=0x61626380, W17=0x000F0000, out_last at t=63, then in_rdy=1 next cycle.
- SHA-1 "abc" block (same words, alg=0): W16=0xC2C4C700, out_last only at t=79, 80 beats total.
- MD5 (alg=2, word i = i): out_w at t=16,17,32,48 = 1,6,5,0 respectively.
- Backpressure: toggle out_rdy randomly during SHA-256 → identical W sequence to the no-stall run, and out_w/out_t stable while out_rdy=0.
- Partial block: in_w_val=16'h7FFF in IDLE → drop=1 for one cycle, no out_val. Then 16'hFFFF → normal capture.
- Reset at t=20 of SHA-1 → next cycle out_val=0, in_rdy=1, all outputs zero. A new block restarts at t=0.
